rps_match: RTL and testbench
============================

# rps_match

Parametrised rock-paper-scissors match engine for the iCEBreaker game designs. It extends the single-round game to an odd number of choices (3 = classic, 5 = rock-paper-scissors-lizard-Spock), with per-button debounce, a timed result display, and first-to-N match scoring. It sits between the board button/PMOD inputs and the LED/PMOD outputs.

## Interface
- `NUM_CHOICES`, default 3: number of choices; must be odd, 3..7. Choice codes are 1..NUM_CHOICES; 0 means none.
- `DEBOUNCE_CYCLES`, default 65536: a synchronised input must hold a stable level this many cycles before the debounced level changes.
- `SHOW_CYCLES`, default 12000000: number of cycles the round result is held in SHOW.
- `WIN_ROUNDS`, default 3: the match ends when either score reaches this value; 1..15.
- `CW`, default $clog2(NUM_CHOICES+1): width of a choice code (derived).
- `SW`, default $clog2(WIN_ROUNDS+1): width of a score (derived).

Ports:
- `CLK`  in  1  system clock. One clock only.
- `RST`  in  1  reset, asynchronous, active-high.
- `BTN`  in  NUM_CHOICES  raw active-high choice buttons; bit i selects choice i+1. The inputs are asynchronous.
- `person_choice`  out  CW  choice captured for the last round.
- `computer_choice`  out  CW  computer choice for the last round.
- `result`  out  3  one-hot round result: 1 = person wins, 2 = computer wins, 4 = tie, 0 = none.
- `person_score`  out  SW  rounds won by the person in the current match.
- `computer_score`  out  SW  rounds won by the computer in the current match.
- `round_done`  out  1  one-cycle pulse when result and scores update.
- `match_over`  out  1  high while in state OVER.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input conditioning:** each BTN bit passes through a 2-flop synchroniser and then an independent debounce counter. Press event = rising edge of the debounced level.
- **Simultaneous presses:** if press events occur in the same cycle, the lowest index wins and the others are discarded.
- **Computer choice:** a free-running counter cycles 1..NUM_CHOICES, advancing every cycle and wrapping from NUM_CHOICES to 1. It is sampled on the press event.
- **Win rule:** d = (p − c) mod NUM_CHOICES. d = 0 is a tie. Odd d means the person wins; even nonzero d means the computer wins. Compute d with a compare-and-add, not a divider.
- **Scoring:** the winner's score increments by 1 and ties leave both scores unchanged. Scores saturate at WIN_ROUNDS.
- **State IDLE:** result = 0 and busy = 0. A press event moves the FSM to EVAL.
- **State EVAL (1 cycle):** person_choice, computer_choice, result and scores are registered; round_done pulses. Next state is SHOW.
- **State SHOW:** held for SHOW_CYCLES cycles. All press events are ignored. At the end:
  - if either score equals WIN_ROUNDS, go to OVER;
  - otherwise go to RELEASE.
- **State RELEASE:** waits until all debounced levels are 0, then returns to IDLE. The result output keeps its value until IDLE is entered.
- **State OVER:** match_over = 1, and result and scores are held. The first press event after all debounced levels are 0 clears both scores, result and both choices, and returns the FSM to IDLE. That press does not start a round.
- **Reset:** all outputs are 0, the FSM is in IDLE, debounce levels and counters are 0, and the choice counter is 1. Asserting RST mid-round or mid-match aborts immediately to this state.

## Timing
- **Latency:** a debounced rising edge registered at cycle t gives EVAL at cycle t+1. Outputs and the round_done pulse are visible at t+2.
- **Raw-to-output latency:** 2 synchroniser cycles + DEBOUNCE_CYCLES + 2.
- **SHOW length:** SHOW lasts exactly SHOW_CYCLES cycles, counted from the first cycle after EVAL.
- **Throughput:** at most one round per press and release. A button held through SHOW never generates a second round.
- **Registered outputs:** all outputs are registered, with no combinational path from BTN.

## Test plan
- **Reset:** assert RST mid-SHOW with scores 2:1 → all outputs 0 within the same cycle (async); after release, busy = 0.
- **Classic table:** NUM_CHOICES=3, force computer_choice via press timing. Rock(1) vs scissors(3) → result=1, person_score +1. Rock vs paper(2) → result=2. Paper vs paper → result=4 with scores unchanged. round_done is one cycle, at t+2.
- **Five choices:** NUM_CHOICES=5. p=5, c=1 → d=4 → result=2. p=2, c=1 → result=1. Sweep all 25 pairs against the d-parity model.
- **Debounce:** BTN[0] glitches of DEBOUNCE_CYCLES−1 → no round. Hold for DEBOUNCE_CYCLES → exactly one round. BTN[0] and BTN[2] pressed in the same cycle → person_choice=1.
- **Match end:** WIN_ROUNDS=2, person wins two rounds → match_over=1 after the second SHOW and scores stay 2:0. The next press after release → scores 0:0, result 0, IDLE, and no round_done.
- **Hold/ignore:** keep BTN[1] held through SHOW and press BTN[0] during SHOW → only one round_done. The FSM stays in RELEASE until BTN[1] is released.

Source files
------------

// File: rtl/rps_match.sv
// Rock-paper-scissors(-lizard-Spock) match engine: per-button sync/debounce,
// round evaluation, timed result display and first-to-WIN_ROUNDS scoring.

module rps_debounce #(
   parameter int CYCLES = 65536
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw,
   output logic level
);
   localparam int DW = $clog2(CYCLES + 1);

   logic [1:0]    sync;
   logic [DW-1:0] cnt;

   // Level flips only after the synchronised input disagrees for CYCLES cycles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == DW'(CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module rps_match #(
   parameter int NUM_CHOICES     = 3,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int SHOW_CYCLES     = 12000000,
   parameter int WIN_ROUNDS      = 3,
   parameter int CW              = $clog2(NUM_CHOICES + 1),
   parameter int SW              = $clog2(WIN_ROUNDS + 1)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_CHOICES-1:0] BTN,
   output logic [CW-1:0]          person_choice,
   output logic [CW-1:0]          computer_choice,
   output logic [2:0]             result,
   output logic [SW-1:0]          person_score,
   output logic [SW-1:0]          computer_score,
   output logic                   round_done,
   output logic                   match_over,
   output logic                   busy
);
   localparam int SHW = $clog2(SHOW_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, EVAL, SHOW, RELEASE, OVER} state_t;

   state_t                 state;
   logic [NUM_CHOICES-1:0] deb, deb_q, press;
   logic [CW-1:0]          ccnt, pick, cap_p, cap_c;
   logic [CW:0]            d;
   logic [2:0]             round_res;
   logic [SHW-1:0]         show_cnt;
   logic                   armed, any_press;

   for (genvar i = 0; i < NUM_CHOICES; i++) begin : g_deb
      rps_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .CLK   (CLK),
         .RST   (RST),
         .raw   (BTN[i]),
         .level (deb[i])
      );
   end

   assign press     = deb & ~deb_q;
   assign any_press = |press;

   // Lowest-index press wins when several land in the same cycle.
   always_comb begin
      pick = '0;
      for (int i = NUM_CHOICES - 1; i >= 0; i--)
         if (press[i]) pick = CW'(i + 1);
   end

   // d = (p - c) mod N, computed with a compare-and-add.
   always_comb begin
      if (cap_p >= cap_c) d = {1'b0, cap_p} - {1'b0, cap_c};
      else                d = {1'b0, cap_p} + (CW+1)'(NUM_CHOICES) - {1'b0, cap_c};
      if (d == '0)        round_res = 3'b100;
      else if (d[0])      round_res = 3'b001;
      else                round_res = 3'b010;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         deb_q <= '0;
         ccnt  <= CW'(1);
      end else begin
         deb_q <= deb;
         ccnt  <= (ccnt == CW'(NUM_CHOICES)) ? CW'(1) : ccnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state           <= IDLE;
         cap_p           <= '0;
         cap_c           <= '0;
         show_cnt        <= '0;
         armed           <= 1'b0;
         person_choice   <= '0;
         computer_choice <= '0;
         result          <= '0;
         person_score    <= '0;
         computer_score  <= '0;
         round_done      <= 1'b0;
         match_over      <= 1'b0;
         busy            <= 1'b0;
      end else begin
         round_done <= 1'b0;
         case (state)
            IDLE: if (any_press) begin
               cap_p <= pick;
               cap_c <= ccnt;
               busy  <= 1'b1;
               state <= EVAL;
            end
            EVAL: begin
               person_choice   <= cap_p;
               computer_choice <= cap_c;
               result          <= round_res;
               if (round_res[0] && person_score != SW'(WIN_ROUNDS))
                  person_score <= person_score + 1'b1;
               if (round_res[1] && computer_score != SW'(WIN_ROUNDS))
                  computer_score <= computer_score + 1'b1;
               round_done <= 1'b1;
               show_cnt   <= '0;
               state      <= SHOW;
            end
            SHOW: begin
               if (show_cnt == SHW'(SHOW_CYCLES - 1)) begin
                  if (person_score == SW'(WIN_ROUNDS) || computer_score == SW'(WIN_ROUNDS)) begin
                     match_over <= 1'b1;
                     armed      <= 1'b0;
                     state      <= OVER;
                  end else begin
                     state <= RELEASE;
                  end
               end else begin
                  show_cnt <= show_cnt + 1'b1;
               end
            end
            RELEASE: if (deb == '0) begin
               result <= '0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            OVER: begin
               if (deb == '0) armed <= 1'b1;
               // A fresh press after full release only clears the match.
               if (armed && any_press) begin
                  person_choice   <= '0;
                  computer_choice <= '0;
                  result          <= '0;
                  person_score    <= '0;
                  computer_score  <= '0;
                  match_over      <= 1'b0;
                  busy            <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rps_match.sv
// Bench for rps_match: a classic 3-choice instance (first to 2) and a
// 5-choice instance, with a per-instance queue of expected round outcomes.

module tb_rps_match;
   localparam int D  = 4;
   localparam int SH = 10;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [2:0] btn3 = '0;
   logic [4:0] btn5 = '0;

   logic [1:0] pc3, cc3, ps3, cs3;
   logic [2:0] res3;
   logic       rd3, mo3, bz3;
   logic [2:0] pc5, cc5, res5;
   logic [3:0] ps5, cs5;
   logic       rd5, mo5, bz5;

   rps_match #(.NUM_CHOICES(3), .DEBOUNCE_CYCLES(D), .SHOW_CYCLES(SH), .WIN_ROUNDS(2)) u3 (
      .CLK(CLK), .RST(RST), .BTN(btn3), .person_choice(pc3), .computer_choice(cc3),
      .result(res3), .person_score(ps3), .computer_score(cs3), .round_done(rd3),
      .match_over(mo3), .busy(bz3));

   rps_match #(.NUM_CHOICES(5), .DEBOUNCE_CYCLES(D), .SHOW_CYCLES(SH), .WIN_ROUNDS(15)) u5 (
      .CLK(CLK), .RST(RST), .BTN(btn5), .person_choice(pc5), .computer_choice(cc5),
      .result(res5), .person_score(ps5), .computer_score(cs5), .round_done(rd5),
      .match_over(mo5), .busy(bz5));

   always #5 CLK = ~CLK;

   typedef struct {int p; int c; int res; int ps; int cs; int due;} exp_t;
   typedef struct {int pmask; int c; int res;} vec_t;

   exp_t q3[$], q5[$];
   vec_t v3[4], v5[2];
   int   tests = 0, fails = 0;
   int   ecount;
   int   psm[2], csm[2];

   // Clock edges since reset: the choice counter shows (ecount mod N) + 1.
   always @(posedge CLK or posedge RST)
      if (RST) ecount <= 0;
      else     ecount <= ecount + 1;

   function automatic int nch(input int inst);  return (inst == 0) ? 3 : 5;  endfunction
   function automatic int winr(input int inst); return (inst == 0) ? 2 : 15; endfunction

   function automatic int model_res(input int p, input int c, input int n);
      int d;
      d = (p - c + n) % n;
      if (d == 0) return 4;
      return (d % 2 == 1) ? 1 : 2;
   endfunction

   function automatic int low_bit(input int m);
      for (int i = 0; i < 8; i++) if (m[i]) return i + 1;
      return 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic mon(input int inst, input int p, input int c, input int r, input int ps, input int cs);
      exp_t e;
      tests++;
      if ((inst == 0) ? (q3.size() == 0) : (q5.size() == 0)) begin
         fails++;
         $display("FAIL unexpected_round_done inst%0d at cycle %0d", inst, ecount);
      end else begin
         e = (inst == 0) ? q3.pop_front() : q5.pop_front();
         if (p != e.p || c != e.c || r != e.res || ps != e.ps || cs != e.cs || ecount != e.due) begin
            fails++;
            $display("FAIL round inst%0d: got p=%0d c=%0d res=%0d score=%0d:%0d cyc=%0d, expected p=%0d c=%0d res=%0d score=%0d:%0d cyc=%0d",
                     inst, p, c, r, ps, cs, ecount, e.p, e.c, e.res, e.ps, e.cs, e.due);
         end
      end
   endtask

   always @(negedge CLK) begin
      if (rd3) mon(0, int'(pc3), int'(cc3), int'(res3), int'(ps3), int'(cs3));
      if (rd5) mon(1, int'(pc5), int'(cc5), int'(res5), int'(ps5), int'(cs5));
   end

   // Press timed so the counter shows cwant in the press-event cycle.
   task automatic drive_round(input int inst, input int pmask, input int cwant, input int res,
                              input int hold, input bit keep);
      int   n, g;
      exp_t e;
      n = nch(inst);
      g = 0;
      @(negedge CLK);
      while (((ecount + D + 2) % n) + 1 != cwant && g < 20) begin
         @(negedge CLK);
         g++;
      end
      if (res == 1 && psm[inst] < winr(inst)) psm[inst]++;
      if (res == 2 && csm[inst] < winr(inst)) csm[inst]++;
      e = '{low_bit(pmask), cwant, res, psm[inst], csm[inst], ecount + D + 4};
      if (inst == 0) begin q3.push_back(e); btn3 = 3'(pmask); end
      else           begin q5.push_back(e); btn5 = 5'(pmask); end
      repeat (hold) @(negedge CLK);
      if (!keep) begin btn3 = '0; btn5 = '0; end
      while (ecount < e.due) @(negedge CLK);
   endtask

   task automatic wait_idle(input int inst);
      int g;
      g = 0;
      while (((inst == 0) ? bz3 : bz5) && g < 300) begin
         @(negedge CLK);
         g++;
      end
      chk("idle_timeout", int'(g < 300), 1);
   endtask

   initial begin
      v3 = '{'{1, 3, 1}, '{1, 2, 2}, '{2, 2, 4}, '{4, 2, 1}};
      v5 = '{'{16, 1, 2}, '{2, 1, 1}};
      psm = '{0, 0};
      csm = '{0, 0};

      repeat (3) @(negedge CLK);
      chk("reset_pc", int'(pc3), 0);
      chk("reset_result", int'(res3), 0);
      chk("reset_scores", int'({ps3, cs3}), 0);
      chk("reset_flags", int'({rd3, mo3, bz3, rd5, mo5, bz5}), 0);
      chk("reset_cc5", int'(cc5), 0);
      RST = 1'b0;

      // Classic table: win, loss, tie; scores go 1:0, 1:1, 1:1.
      for (int i = 0; i < 3; i++) begin
         drive_round(0, v3[i].pmask, v3[i].c, v3[i].res, D + 2, 1'b0);
         wait_idle(0);
      end
      chk("tie_scores", int'({ps3, cs3}), 'b0101);

      // Reach 2:1, then reset asynchronously in the middle of SHOW.
      drive_round(0, v3[3].pmask, v3[3].c, v3[3].res, D + 2, 1'b0);
      repeat (2) @(negedge CLK);
      chk("show_busy", int'(bz3), 1);
      RST = 1'b1;
      #1;
      chk("async_rst_outputs", int'({pc3, cc3, res3, ps3, cs3}), 0);
      chk("async_rst_flags", int'({rd3, mo3, bz3}), 0);
      psm = '{0, 0};
      csm = '{0, 0};
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_busy", int'(bz3), 0);

      // Match end: two person wins reach OVER and hold 2:0.
      drive_round(0, 1, 3, 1, D + 2, 1'b0);
      wait_idle(0);
      drive_round(0, 1, 3, 1, D + 2, 1'b0);
      for (int g = 0; g < 100 && !mo3; g++) @(negedge CLK);
      chk("match_over", int'(mo3), 1);
      chk("over_scores", int'({ps3, cs3}), 'b1000);
      chk("over_result", int'(res3), 1);
      chk("over_busy", int'(bz3), 1);
      repeat (D + 6) @(negedge CLK);
      chk("over_held", int'({mo3, ps3, cs3}), 'b11000);
      btn3 = 3'b010;
      repeat (D + 2) @(negedge CLK);
      btn3 = '0;
      repeat (D + 4) @(negedge CLK);
      chk("clear_scores", int'({ps3, cs3}), 0);
      chk("clear_outputs", int'({pc3, cc3, res3}), 0);
      chk("clear_flags", int'({mo3, bz3}), 0);
      psm[0] = 0;
      csm[0] = 0;
      repeat (D + 4) @(negedge CLK);

      // Debounce: a DEBOUNCE_CYCLES-1 glitch does nothing.
      btn3 = 3'b001;
      repeat (D - 1) @(negedge CLK);
      btn3 = '0;
      repeat (D + 10) @(negedge CLK);
      chk("glitch_no_round", int'(bz3), 0);

      // Exactly DEBOUNCE_CYCLES high gives one round; then a simultaneous press.
      drive_round(0, 1, 2, 2, D, 1'b0);
      wait_idle(0);
      drive_round(0, 5, 1, 4, D + 2, 1'b0);
      wait_idle(0);

      // Hold BTN[1] through SHOW and tap BTN[0] during SHOW.
      drive_round(0, 2, 1, 1, D + 2, 1'b1);
      btn3 = 3'b011;
      repeat (D + 1) @(negedge CLK);
      btn3 = 3'b010;
      repeat (SH + 2 * D) @(negedge CLK);
      chk("release_wait_busy", int'(bz3), 1);
      chk("release_result_held", int'(res3), 1);
      btn3 = '0;
      wait_idle(0);
      chk("hold_scores", int'({ps3, cs3}), 'b0101);

      // Five choices: two named vectors, then all 25 pairs.
      for (int i = 0; i < 2; i++) begin
         drive_round(1, v5[i].pmask, v5[i].c, v5[i].res, D + 2, 1'b0);
         wait_idle(1);
      end
      for (int p = 1; p <= 5; p++)
         for (int c = 1; c <= 5; c++) begin
            drive_round(1, 1 << (p - 1), c, model_res(p, c, 5), D + 2, 1'b0);
            wait_idle(1);
         end
      chk("five_scores", int'({ps5, cs5}), (11 << 4) | 11);
      chk("five_not_over", int'(mo5), 0);

      repeat (5) @(negedge CLK);
      chk("pending_rounds", q3.size() + q5.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
